op_seq_ctrl: RTL and testbench
==============================

Name: op_seq_ctrl

Overview:
- Operation sequencer that drives the address generator's interface in the polynomial arithmetic core.
- Accepts a start/mode command and generates the per-cycle clk_counter sweep the address generator consumes.
- Waits out the butterfly/RAM pipeline latency, then reports completion.
- One instance per arithmetic core; it sits between the top-level controller and addr_gen.

Parameters:
- CNT_W, 8, width of clk_counter
- NTT_LEN, 224, counter steps for NTT and INVNTT (7 layers x 32)
- MULT_LEN, 64, counter steps for MULT
- ADDSUB_LEN, 64, counter steps for ADDSUB
- PIPE_LAT, 4, drain cycles after the last count (0..15; 0 allowed)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command request; level-sampled
- mode  in  2  0:NTT, 1:INVNTT, 2:MULT, 3:ADDSUB; sampled with accepted start
- mode_q  out  2  latched mode for addr_gen
- clk_counter  out  CNT_W  step index for addr_gen
- cnt_valid  out  1  clk_counter is a live step this cycle
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state IDLE; mode_q=0, clk_counter=0, cnt_valid=0, busy=0, done=0.
- Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered.
- LEN is selected from mode_q: NTT_LEN for 0 and 1, MULT_LEN for 2, ADDSUB_LEN for 3.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - On acceptance, mode_q<=mode, clk_counter<=0, cnt_valid<=1, busy<=1, and the state goes to RUN.
  - start and mode in RUN/DRAIN are ignored; mode_q does not change.
- RUN:
  - clk_counter increments by 1 per cycle, 0..LEN-1; cnt_valid=1 for exactly LEN cycles.
  - After the cycle showing LEN-1: clk_counter<=0, cnt_valid<=0.
  - Next state is DRAIN if PIPE_LAT>0, else DONE.
- DRAIN:
  - Internal 4-bit drain counter runs for PIPE_LAT cycles; busy=1, cnt_valid=0, clk_counter=0.
  - Then the state goes to DONE.
- DONE:
  - done=1, busy=0, held for one cycle.
  - Next state is IDLE, or RUN if start=1 (back-to-back runs, one-cycle gap).
- Latency: if start is sampled at edge E0, done is high in the cycle following edge E0+LEN+PIPE_LAT.
- clk_counter never exceeds LEN-1; no wrap is visible to addr_gen.
- Width rule: LEN<=2^CNT_W (elaboration check).

Optional Feature:
- Macro: OP_SEQ_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - In RUN with pause=1, clk_counter holds and cnt_valid=0 that cycle; stepping resumes from the held value when pause=0.
  - pause has no effect in IDLE, DRAIN or DONE.
  - Total latency grows by exactly the number of paused RUN cycles.
- Undefined: no pause port; RUN never stalls.

Decomposition:
- Package op_seq_pkg holds:
  - mode encodings MODE_NTT=0, MODE_INVNTT=1, MODE_MULT=2, MODE_ADDSUB=3
  - state encodings
  - default LEN/PIPE_LAT constants
- addr_gen includes the same package.
- No sub-module; the LEN selection is a small function in the package.

Test Plan:
- mode=0, start one cycle:
  - clk_counter 0..223 with cnt_valid=1 for 224 cycles, then 4 drain cycles with busy=1.
  - done=1 in cycle 229 after the start edge; mode_q=0.
- mode=2, start:
  - clk_counter 0..63, done 69 cycles after start.
  - mode driven to 3 and start pulsed at count 10: ignored, mode_q stays 2, sequence unchanged.
- start held high, mode=3:
  - Runs repeat back-to-back; each done cycle is immediately followed by clk_counter=0, cnt_valid=1.
  - Spacing is 69 cycles per run.
- rst_n low at clk_counter=100 (mode=1):
  - Immediately, without waiting for a clock: clk_counter=0, busy=0, cnt_valid=0.
  - No done; the next start begins again from 0.
- PIPE_LAT=0, mode=2: done in cycle 65 after start; no DRAIN cycle observed.
- OP_SEQ_PAUSE_EN, mode=0, pause high for 5 cycles at count 50:
  - clk_counter holds at 50 with cnt_valid=0.
  - done at cycle 234.

Source files
------------

// File: rtl/op_seq_pkg.sv
// rtl/op_seq_pkg.sv - shared mode/state encodings and length selection for op_seq_ctrl and addr_gen
package op_seq_pkg;

  typedef enum logic [1:0] {
    MODE_NTT    = 2'd0,
    MODE_INVNTT = 2'd1,
    MODE_MULT   = 2'd2,
    MODE_ADDSUB = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_NTT_LEN    = 224;
  localparam int unsigned DEF_MULT_LEN   = 64;
  localparam int unsigned DEF_ADDSUB_LEN = 64;
  localparam int unsigned DEF_PIPE_LAT   = 4;

  // NTT and INVNTT share the same 7x32 butterfly sweep.
  function automatic int unsigned sel_len(input mode_e m, input int unsigned ntt_len,
                                          input int unsigned mult_len, input int unsigned addsub_len);
    case (m)
      MODE_MULT:   return mult_len;
      MODE_ADDSUB: return addsub_len;
      default:     return ntt_len;
    endcase
  endfunction

endpackage

// File: rtl/op_seq_ctrl.sv
// rtl/op_seq_ctrl.sv - operation sequencer driving the addr_gen step sweep; optional OP_SEQ_PAUSE_EN adds a RUN stall input
module op_seq_ctrl
  import op_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned NTT_LEN    = DEF_NTT_LEN,
  parameter int unsigned MULT_LEN   = DEF_MULT_LEN,
  parameter int unsigned ADDSUB_LEN = DEF_ADDSUB_LEN,
  parameter int unsigned PIPE_LAT   = DEF_PIPE_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
`ifdef OP_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic [1:0]       mode_q,
  output logic [CNT_W-1:0] clk_counter,
  output logic             cnt_valid,
  output logic             busy,
  output logic             done
);

  if ((NTT_LEN > (1 << CNT_W)) || (MULT_LEN > (1 << CNT_W)) || (ADDSUB_LEN > (1 << CNT_W))) begin : g_bad_len
    $error("op_seq_ctrl: a sweep length exceeds 2**CNT_W");
  end
  if (PIPE_LAT > 15) begin : g_bad_lat
    $error("op_seq_ctrl: PIPE_LAT must be 0..15");
  end

  localparam logic [3:0] DRAIN_LAST = (PIPE_LAT == 0) ? 4'd0 : 4'(PIPE_LAT - 1);

  state_e           state, next_state;
  logic [3:0]       drain_cnt, drain_d;
  logic [CNT_W-1:0] last_idx, cnt_d;
  logic [1:0]       mode_d;
  logic             valid_d, busy_d, done_d;
  logic             accept, stall, last_step;

`ifdef OP_SEQ_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign last_idx  = CNT_W'(sel_len(mode_e'(mode_q), NTT_LEN, MULT_LEN, ADDSUB_LEN) - 1);
  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_step = (state == ST_RUN) && !stall && (clk_counter == last_idx);

  // State and all outputs are registered together so addr_gen sees glitch-free values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      drain_cnt   <= 4'd0;
      mode_q      <= 2'd0;
      clk_counter <= '0;
      cnt_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= next_state;
      drain_cnt   <= drain_d;
      mode_q      <= mode_d;
      clk_counter <= cnt_d;
      cnt_valid   <= valid_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_RUN;
      ST_RUN:   if (last_step) next_state = (PIPE_LAT > 0) ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) next_state = ST_DONE;
      ST_DONE:  next_state = accept ? ST_RUN : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // A paused RUN cycle holds the step index but withdraws cnt_valid.
  always_comb begin
    mode_d  = accept ? mode : mode_q;
    cnt_d   = '0;
    drain_d = 4'd0;
    if (state == ST_RUN && !last_step) begin
      cnt_d = stall ? clk_counter : clk_counter + CNT_W'(1);
    end
    if (state == ST_DRAIN) begin
      drain_d = drain_cnt + 4'd1;
    end
    valid_d = (next_state == ST_RUN) && !((state == ST_RUN) && stall);
    busy_d  = (next_state == ST_RUN) || (next_state == ST_DRAIN);
    done_d  = (next_state == ST_DONE);
  end

endmodule

// File: tb/tb_op_seq_ctrl.sv
// tb/tb_op_seq_ctrl.sv - directed self-checking bench for op_seq_ctrl (pause steps under OP_SEQ_PAUSE_EN)
module tb_op_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start0;
  logic [1:0] mode, mode0;
  logic [1:0] mode_q, mode_q0;
  logic [7:0] clk_counter, clk_counter0;
  logic       cnt_valid, cnt_valid0, busy, busy0, done, done0;
`ifdef OP_SEQ_PAUSE_EN
  logic       pause;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  op_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
`ifdef OP_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .mode_q(mode_q), .clk_counter(clk_counter), .cnt_valid(cnt_valid),
    .busy(busy), .done(done)
  );

  op_seq_ctrl #(.PIPE_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0),
`ifdef OP_SEQ_PAUSE_EN
    .pause(1'b0),
`endif
    .mode_q(mode_q0), .clk_counter(clk_counter0), .cnt_valid(cnt_valid0),
    .busy(busy0), .done(done0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " idle done"}, 32'(done), 0);
    chk({tag, " idle busy"}, 32'(busy), 0);
    chk({tag, " idle valid"}, 32'(cnt_valid), 0);
  endtask

  // Entered in cycle 1 after the accepting edge; returns in the done cycle.
  task automatic check_run(input int len, input int lat, input logic [1:0] m, input bit sel,
                           input int inj, input string tag);
    for (int k = 1; k <= len; k++) begin
      if (k == inj) begin
        start = 1'b1;
        mode  = 2'd3;
      end else if (k == inj + 1) begin
        start = 1'b0;
      end
      chk({tag, " cnt"},   32'(sel ? clk_counter0 : clk_counter), 32'(k - 1));
      chk({tag, " valid"}, 32'(sel ? cnt_valid0 : cnt_valid), 1);
      chk({tag, " busy"},  32'(sel ? busy0 : busy), 1);
      chk({tag, " done"},  32'(sel ? done0 : done), 0);
      step();
    end
    for (int k = 0; k < lat; k++) begin
      chk({tag, " drain cnt"},   32'(sel ? clk_counter0 : clk_counter), 0);
      chk({tag, " drain valid"}, 32'(sel ? cnt_valid0 : cnt_valid), 0);
      chk({tag, " drain busy"},  32'(sel ? busy0 : busy), 1);
      chk({tag, " drain done"},  32'(sel ? done0 : done), 0);
      step();
    end
    chk({tag, " done pulse"}, 32'(sel ? done0 : done), 1);
    chk({tag, " done busy"},  32'(sel ? busy0 : busy), 0);
    chk({tag, " done valid"}, 32'(sel ? cnt_valid0 : cnt_valid), 0);
    chk({tag, " mode_q"},     32'(sel ? mode_q0 : mode_q), 32'(m));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; start0 = 1'b0; mode0 = 2'd0;
`ifdef OP_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) step();
    chk("rst cnt", 32'(clk_counter), 0);
    chk("rst valid", 32'(cnt_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst mode_q", 32'(mode_q), 0);
    rst_n = 1'b1;
    step();

    // NTT: 224 steps + 4 drain, done in cycle 229
    mode = 2'd0; start = 1'b1;
    step();
    start = 1'b0;
    check_run(224, 4, 2'd0, 1'b0, -1, "ntt");
    step();
    chk_idle("ntt");

    // MULT with an ignored start/mode=3 at count 10
    mode = 2'd2; start = 1'b1;
    step();
    start = 1'b0;
    check_run(64, 4, 2'd2, 1'b0, 11, "mult");
    step();
    chk_idle("mult");

    // ADDSUB with start held: back-to-back runs 69 cycles apart
    mode = 2'd3; start = 1'b1;
    step();
    check_run(64, 4, 2'd3, 1'b0, -1, "b2b1");
    step();
    start = 1'b0;
    check_run(64, 4, 2'd3, 1'b0, -1, "b2b2");
    step();
    chk_idle("b2b");

    // Asynchronous abort at count 100 of INVNTT
    mode = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (100) step();
    chk("abort pre cnt", 32'(clk_counter), 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort cnt", 32'(clk_counter), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort valid", 32'(cnt_valid), 0);
    chk("abort mode_q", 32'(mode_q), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort no done", 32'(done), 0);
    end
    rst_n = 1'b1;
    step();
    chk("abort after no done", 32'(done), 0);
    mode = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    check_run(224, 4, 2'd1, 1'b0, -1, "restart");
    step();
    chk_idle("restart");

    // PIPE_LAT=0 instance: done in cycle 65, no drain
    mode0 = 2'd2; start0 = 1'b1;
    step();
    start0 = 1'b0;
    check_run(64, 0, 2'd2, 1'b1, -1, "lat0");
    step();
    chk("lat0 idle done", 32'(done0), 0);
    chk("lat0 idle busy", 32'(busy0), 0);

`ifdef OP_SEQ_PAUSE_EN
    // Pause 5 RUN cycles at count 50: done moves to cycle 234
    mode = 2'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 234; k++) begin
      if (k == 51) pause = 1'b1;
      if (k == 56) pause = 1'b0;
      if (k <= 51) begin
        chk("pause cnt", 32'(clk_counter), 32'(k - 1));
        chk("pause valid", 32'(cnt_valid), 1);
      end else if (k <= 56) begin
        chk("pause hold cnt", 32'(clk_counter), 50);
        chk("pause hold valid", 32'(cnt_valid), 0);
        chk("pause hold busy", 32'(busy), 1);
      end else if (k <= 229) begin
        chk("pause resume cnt", 32'(clk_counter), 32'(k - 6));
        chk("pause resume valid", 32'(cnt_valid), 1);
      end else if (k <= 233) begin
        chk("pause drain busy", 32'(busy), 1);
        chk("pause drain valid", 32'(cnt_valid), 0);
      end
      chk("pause done", 32'(done), (k == 234) ? 1 : 0);
      if (k < 234) step();
    end
    step();
    chk_idle("pause");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
